alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Upstream control stage for the ALU select decoder (2-to-4, inputs S0/S1/enable, one-hot y). It accepts 2-bit ALU op requests over a valid/ready handshake and buffers them in a small FIFO. It then replays them onto registered select lines: each op holds enable high for a fixed number of cycles, followed by a mandatory idle gap. It sits between the instruction/control path and the decoder, and owns all timing of decoder enable.

Parameters:
DEPTH, 4, op FIFO depth in entries; power of two, 2..16.
HOLD, 2, cycles sel_en stays high per op; 1..15.
GAP, 1, idle cycles with sel_en low after each op; 0..15 (0 = back-to-back).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
op_valid  input  1  request present
op_code  input  2  requested op; bit0 -> S0, bit1 -> S1
op_ready  output  1  FIFO can accept; transfer when op_valid && op_ready at rising edge
sel_s0  output  1  to decoder S0
sel_s1  output  1  to decoder S1
sel_en  output  1  to decoder enable
op_done  output  1  one-cycle pulse on last HOLD cycle of each op
busy  output  1  FSM not IDLE or FIFO non-empty
fifo_count  output  $clog2(DEPTH+1)  entries currently buffered (3 bits at default)

Behaviour:
- Reset (rst_n low at rising edge, synchronous, overrides all):
  - FIFO emptied; pointers and counters cleared; FSM to IDLE.
  - sel_s0 = sel_s1 = sel_en = op_done = busy = 0; fifo_count = 0.
  - op_ready = 1 from the first cycle after reset.
  - Reset mid-op aborts the op: sel_en drops to 0 the cycle after the reset edge, and no op_done is emitted.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - op_ready = (fifo_count != DEPTH), combinational from registered count only; it does not depend on op_valid.
  - Push on op_valid && op_ready. Pop when the FSM leaves IDLE or GAP to start an op.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push when full: ignored, op_ready = 0.
  - No bypass: an op always passes through the FIFO.
- FSM states: IDLE, ISSUE, GAP. All outputs except op_ready are registered.
  - IDLE: sel_en = 0, sel_s0 = sel_s1 = 0. If FIFO non-empty: pop head, load sel_s0/sel_s1 from it, set sel_en = 1, load hold counter = HOLD-1, go ISSUE.
  - ISSUE: sel_s0/sel_s1/sel_en held stable. If hold counter != 0, decrement. If hold counter == 0, op_done = 1 this cycle and at the edge:
    - GAP > 0: go GAP, load gap counter = GAP-1, sel_en = 0, sel_s0 = sel_s1 = 0.
    - GAP == 0 and FIFO non-empty: pop next op directly and stay in ISSUE; sel_en stays 1 and sel_s0/sel_s1 update.
    - GAP == 0 and FIFO empty: go IDLE.
  - GAP: sel_en = 0. When gap counter == 0: pop and start ISSUE if FIFO non-empty, else go IDLE. Otherwise decrement.
- Latency: an op accepted at edge N into an empty, idle sequencer drives sel_en = 1 from edge N+1 through edge N+1+HOLD. op_done is high during the cycle ending at edge N+1+HOLD.
- Per op, sel_en is high for exactly HOLD consecutive cycles; select lines never change while sel_en = 1, except at a GAP = 0 op boundary.
- busy = (state != IDLE) || (fifo_count != 0), registered.

Test Plan:
1. Reset then idle -> sel_en = 0, op_ready = 1, fifo_count = 0, busy = 0 for 10 cycles.
2. Single op_code = 2'b10, defaults -> sel_en = 1 with sel_s1 = 1 and sel_s0 = 0 for exactly 2 cycles starting 1 cycle after acceptance; op_done pulses once on the 2nd cycle; then sel_en = 0 for 1 cycle; decoder y = 4'b0100 during issue (decoder index = {S1,S0}).
3. Push 5 ops back-to-back (00, 01, 10, 11, 01) while the FSM is stalled in ISSUE on op 1 -> op_ready drops when fifo_count = 4; the 5th push is held until a pop; all 5 ops emerge in order; fifo_count returns to 0 and busy goes 0.
4. GAP = 0, HOLD = 1, stream 00, 01, 11 -> sel_en continuously high for 3 cycles; selects change every cycle; 3 op_done pulses.
5. Push and pop in the same cycle with fifo_count = 2 -> fifo_count stays 2; the pushed op is issued after the queued two (tests pointer wrap after ≥ DEPTH ops).
6. rst_n low during the 1st ISSUE cycle with 2 ops queued -> sel_en = 0 next cycle, no op_done, fifo_count = 0, queued ops discarded.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: buffers 2-bit op requests in a FIFO and replays each one onto
// the decoder select lines, holding enable for HOLD cycles followed by GAP idle cycles.
//
// state    | meaning
// ST_IDLE  | nothing issuing; starts an op as soon as the FIFO holds one
// ST_ISSUE | sel_en high, selects stable; hold counter runs down to the op's last cycle
// ST_GAP   | sel_en low for GAP cycles before the next op may start
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int GAP   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       op_valid,
    input  logic [1:0]                 op_code,
    output logic                       op_ready,
    output logic                       sel_s0,
    output logic                       sel_s1,
    output logic                       sel_en,
    output logic                       op_done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [3:0]      HOLD_LD = 4'(HOLD - 1);
    localparam logic [3:0]      GAP_LD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [CW-1:0]   FULL    = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [3:0]    hold_q, hold_d;
    logic [3:0]    gap_q, gap_d;
    logic          sel_s0_q, sel_s0_d;
    logic          sel_s1_q, sel_s1_d;
    logic          sel_en_q, sel_en_d;
    logic          op_done_q, op_done_d;
    logic          busy_q, busy_d;

    logic          push;
    logic          pop;
    logic          start_op;
    logic          fifo_ne;
    logic [1:0]    head;

    assign fifo_ne = (count_q != '0);
    assign push    = op_valid && (count_q != FULL);
    assign head    = mem_q[rd_ptr_q];
    assign pop     = start_op;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = op_code;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        sel_s0_d = sel_s0_q;
        sel_s1_d = sel_s1_q;
        sel_en_d = sel_en_q;
        start_op = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel_en_d = 1'b0;
                sel_s0_d = 1'b0;
                sel_s1_d = 1'b0;
                if (fifo_ne) begin
                    start_op = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (hold_q != 4'd0) begin
                    hold_d = hold_q - 4'd1;
                end else if (GAP != 0) begin
                    state_d  = ST_GAP;
                    gap_d    = GAP_LD;
                    sel_en_d = 1'b0;
                    sel_s0_d = 1'b0;
                    sel_s1_d = 1'b0;
                end else if (fifo_ne) begin
                    start_op = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    sel_en_d = 1'b0;
                    sel_s0_d = 1'b0;
                    sel_s1_d = 1'b0;
                end
            end
            ST_GAP: begin
                sel_en_d = 1'b0;
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (fifo_ne) begin
                    start_op = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sel_en_d = 1'b0;
                sel_s0_d = 1'b0;
                sel_s1_d = 1'b0;
            end
        endcase
        if (start_op) begin
            state_d  = ST_ISSUE;
            hold_d   = HOLD_LD;
            sel_s0_d = head[0];
            sel_s1_d = head[1];
            sel_en_d = 1'b1;
        end
    end

    // Registered from next-state values so they line up with the cycle they describe.
    always_comb begin
        op_done_d = (state_d == ST_ISSUE) && (hold_d == 4'd0);
        busy_d    = (state_d != ST_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            hold_q    <= 4'd0;
            gap_q     <= 4'd0;
            sel_s0_q  <= 1'b0;
            sel_s1_q  <= 1'b0;
            sel_en_q  <= 1'b0;
            op_done_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            sel_s0_q  <= sel_s0_d;
            sel_s1_q  <= sel_s1_d;
            sel_en_q  <= sel_en_d;
            op_done_q <= op_done_d;
            busy_q    <= busy_d;
        end
    end

    assign op_ready   = (count_q != FULL);
    assign sel_s0     = sel_s0_q;
    assign sel_s1     = sel_s1_q;
    assign sel_en     = sel_en_q;
    assign op_done    = op_done_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: three timing configurations driven side by side and
// compared every cycle against an issue-schedule model built from op arrival times.
module tb_alu_op_sequencer;

    localparam int NI     = 3;
    localparam int MAXOPS = 1024;
    localparam int QSZ    = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld  [NI];
    logic [1:0] code [NI];
    logic       rdy  [NI];
    logic       s0   [NI];
    logic       s1   [NI];
    logic       en   [NI];
    logic       done [NI];
    logic       bsy  [NI];
    logic [2:0] cnt  [NI];

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(4), .HOLD(2), .GAP(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .op_valid(vld[0]), .op_code(code[0]),
        .op_ready(rdy[0]), .sel_s0(s0[0]), .sel_s1(s1[0]), .sel_en(en[0]),
        .op_done(done[0]), .busy(bsy[0]), .fifo_count(cnt[0]));

    alu_op_sequencer #(.DEPTH(4), .HOLD(1), .GAP(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .op_valid(vld[1]), .op_code(code[1]),
        .op_ready(rdy[1]), .sel_s0(s0[1]), .sel_s1(s1[1]), .sel_en(en[1]),
        .op_done(done[1]), .busy(bsy[1]), .fifo_count(cnt[1]));

    alu_op_sequencer #(.DEPTH(4), .HOLD(6), .GAP(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .op_valid(vld[2]), .op_code(code[2]),
        .op_ready(rdy[2]), .sel_s0(s0[2]), .sel_s1(s1[2]), .sel_en(en[2]),
        .op_done(done[2]), .busy(bsy[2]), .fifo_count(cnt[2]));

    function automatic int hold_of(input int m);
        case (m)
            0:       return 2;
            1:       return 1;
            default: return 6;
        endcase
    endfunction

    function automatic int gap_of(input int m);
        case (m)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vprob = 100;

    // reference model: per accepted op, its arrival edge, start edge and code
    int         a_t    [NI][MAXOPS];
    int         s_t    [NI][MAXOPS];
    logic [1:0] opc    [NI][MAXOPS];
    int         n_acc  [NI];
    int         last_e [NI];

    // per-instance request source
    logic [1:0] pq [NI][QSZ];
    int         ph [NI];
    int         pt [NI];

    // directed observations
    int         en_cyc   [NI];
    int         done_cnt [NI];
    int         run      [NI];
    int         maxrun   [NI];
    int         seen_full[NI];
    int         nseq     [NI];
    logic [1:0] seq      [NI][16];
    logic [3:0] ylast    [NI];
    logic       pen      [NI];
    logic       pdone    [NI];

    logic [1:0] t3 [6];
    logic [1:0] t4 [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < NI; m++) begin
            n_acc[m]  = 0;
            last_e[m] = -1000;
        end
    endtask

    task automatic src_clear();
        for (int m = 0; m < NI; m++) begin
            ph[m] = 0;
            pt[m] = 0;
        end
    endtask

    task automatic enq(input int m, input logic [1:0] c);
        if (ph[m] == pt[m]) begin
            ph[m] = 0;
            pt[m] = 0;
        end
        if (pt[m] < QSZ) begin
            pq[m][pt[m]] = c;
            pt[m]++;
        end
    endtask

    task automatic clear_stats();
        for (int m = 0; m < NI; m++) begin
            en_cyc[m]    = 0;
            done_cnt[m]  = 0;
            run[m]       = 0;
            maxrun[m]    = 0;
            seen_full[m] = 0;
            nseq[m]      = 0;
            ylast[m]     = 4'd0;
        end
    endtask

    function automatic int mcount(input int m, input int t);
        int c = 0;
        for (int k = 0; k < n_acc[m]; k++) begin
            if (a_t[m][k] <= t) c++;
            if (s_t[m][k] <= t) c--;
        end
        return c;
    endfunction

    // An op starts one edge after it arrives, but never before the previous op's
    // HOLD cycles plus GAP idle cycles have elapsed.
    task automatic accept(input int m, input logic [1:0] c);
        int s;
        if (n_acc[m] < MAXOPS) begin
            s = cyc + 1;
            if (last_e[m] + gap_of(m) > s) s = last_e[m] + gap_of(m);
            a_t[m][n_acc[m]] = cyc;
            s_t[m][n_acc[m]] = s;
            opc[m][n_acc[m]] = c;
            last_e[m] = s + hold_of(m);
            n_acc[m]++;
        end
    endtask

    task automatic expect_of(input int m, input int t, output logic [8:0] v);
        int   c;
        int   h;
        int   g;
        logic e_en, e_s0, e_s1, e_done, e_b;
        c = mcount(m, t);
        h = hold_of(m);
        g = gap_of(m);
        e_en = 1'b0; e_s0 = 1'b0; e_s1 = 1'b0; e_done = 1'b0; e_b = 1'b0;
        for (int k = 0; k < n_acc[m]; k++) begin
            if (s_t[m][k] <= t && t < s_t[m][k] + h) begin
                e_en = 1'b1;
                e_s0 = opc[m][k][0];
                e_s1 = opc[m][k][1];
                if (t == s_t[m][k] + h - 1) e_done = 1'b1;
            end
            if (s_t[m][k] <= t && t < s_t[m][k] + h + g) e_b = 1'b1;
        end
        if (c != 0) e_b = 1'b1;
        v = {(c != 4), e_b, e_done, e_en, e_s1, e_s0, 3'(c)};
    endtask

    task automatic step();
        int         prev_cnt [NI];
        logic [8:0] exp_v;
        logic [8:0] obs_v;
        for (int m = 0; m < NI; m++) begin
            prev_cnt[m] = mcount(m, cyc);
            if (ph[m] < pt[m] && $urandom_range(0, 99) < vprob) begin
                vld[m]  = 1'b1;
                code[m] = pq[m][ph[m]];
            end else begin
                vld[m]  = 1'b0;
                code[m] = 2'($urandom);
            end
        end
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int m = 0; m < NI; m++) begin
                if (vld[m] && prev_cnt[m] != 4) begin
                    accept(m, code[m]);
                    ph[m]++;
                end
            end
        end
        #1;
        for (int m = 0; m < NI; m++) begin
            expect_of(m, cyc, exp_v);
            obs_v = {rdy[m], bsy[m], done[m], en[m], s1[m], s0[m], cnt[m]};
            chk($sformatf("cycle dut%0d cyc=%0d {rdy,busy,done,en,s1,s0,cnt}", m, cyc),
                32'(obs_v), 32'(exp_v));
            if (en[m] && (!pen[m] || pdone[m])) begin
                if (nseq[m] < 16) seq[m][nseq[m]] = {s1[m], s0[m]};
                nseq[m]++;
            end
            if (en[m]) begin
                en_cyc[m]++;
                run[m]++;
                ylast[m] = 4'b0001 << {s1[m], s0[m]};
            end else begin
                run[m] = 0;
            end
            if (run[m] > maxrun[m]) maxrun[m] = run[m];
            if (done[m]) done_cnt[m]++;
            if (cnt[m] == 3'd4 && !rdy[m]) seen_full[m] = 1;
            pen[m]   = en[m];
            pdone[m] = done[m];
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic pe;
        int   found;
        t3 = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        t4 = '{2'b00, 2'b01, 2'b11};
        for (int m = 0; m < NI; m++) begin
            vld[m]   = 1'b0;
            code[m]  = 2'b00;
            pen[m]   = 1'b0;
            pdone[m] = 1'b0;
        end
        model_clear();
        src_clear();
        clear_stats();

        // reset, then idle
        rst_n = 1'b0;
        steps(3);
        rst_n = 1'b1;
        steps(10);
        chk("idle_sel_en", 32'(en[0]), 32'd0);
        chk("idle_op_ready", 32'(rdy[0]), 32'd1);
        chk("idle_fifo_count", 32'(cnt[0]), 32'd0);
        chk("idle_busy", 32'(bsy[0]), 32'd0);

        // single op 2'b10
        clear_stats();
        for (int m = 0; m < NI; m++) enq(m, 2'b10);
        vprob = 100;
        steps(14);
        chk("single_en_cycles", 32'(en_cyc[0]), 32'd2);
        chk("single_done_pulses", 32'(done_cnt[0]), 32'd1);
        chk("single_decoder_y", 32'(ylast[0]), 32'h4);
        chk("single_op_count", 32'(nseq[0]), 32'd1);
        chk("single_op_code", 32'(seq[0][0]), 32'h2);

        // back-to-back pushes against a long-hold instance until the FIFO fills
        clear_stats();
        for (int m = 0; m < NI; m++)
            for (int i = 0; i < 6; i++) enq(m, t3[i]);
        steps(80);
        chk("burst_full_seen", 32'(seen_full[2]), 32'd1);
        chk("burst_op_count", 32'(nseq[2]), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("burst_order[%0d]", i), 32'(seq[2][i]), 32'(t3[i]));
        chk("burst_drained_count", 32'(cnt[2]), 32'd0);
        chk("burst_drained_busy", 32'(bsy[2]), 32'd0);

        // zero-gap streaming
        clear_stats();
        for (int m = 0; m < NI; m++)
            for (int i = 0; i < 3; i++) enq(m, t4[i]);
        steps(35);
        chk("stream_en_cycles", 32'(en_cyc[1]), 32'd3);
        chk("stream_en_run", 32'(maxrun[1]), 32'd3);
        chk("stream_done_pulses", 32'(done_cnt[1]), 32'd3);
        chk("stream_op_count", 32'(nseq[1]), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("stream_order[%0d]", i), 32'(seq[1][i]), 32'(t4[i]));

        // reset on the first issue cycle of an op with two more queued
        for (int m = 0; m < NI; m++)
            for (int i = 0; i < 4; i++) enq(m, 2'($urandom));
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            pe = pen[0];
            step();
            if (en[0] && !pe && cnt[0] == 3'd2) found = 1;
        end
        chk("abort_issue_reached", 32'(found), 32'd1);
        src_clear();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_sel_en", 32'(en[0]), 32'd0);
        chk("abort_op_done", 32'(done[0]), 32'd0);
        chk("abort_fifo_count", 32'(cnt[0]), 32'd0);
        clear_stats();
        steps(12);
        chk("abort_no_replay_en", 32'(en_cyc[0]), 32'd0);
        chk("abort_no_replay_done", 32'(done_cnt[0]), 32'd0);

        // randomized traffic with a reset in the middle
        for (int blk = 0; blk < 10; blk++) begin
            case ($urandom_range(0, 2))
                0:       vprob = 30;
                1:       vprob = 70;
                default: vprob = 100;
            endcase
            for (int i = 0; i < 50; i++) begin
                for (int m = 0; m < NI; m++)
                    if (pt[m] - ph[m] < 3 && $urandom_range(0, 99) < 60) enq(m, 2'($urandom));
                if (blk == 5 && i == 20) begin
                    src_clear();
                    rst_n = 1'b0;
                end
                if (blk == 5 && i == 22) rst_n = 1'b1;
                step();
            end
        end

        // drain
        vprob = 100;
        steps(120);
        for (int m = 0; m < NI; m++) begin
            chk($sformatf("final_count_dut%0d", m), 32'(cnt[m]), 32'd0);
            chk($sformatf("final_busy_dut%0d", m), 32'(bsy[m]), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
